cmsdk_reset_sequencer: RTL
==========================

Name: cmsdk_reset_sequencer

Overview:
Reset sequencer directly downstream of the simulation clock/power-on reset generator. Takes the raw clock and a raw asynchronous active-high reset, and produces staged, CLK-synchronous active-low resets for the Cortex-M0 subsystem: PORESETN first, then HRESETN. Also re-asserts HRESETN alone on a core system reset request or a lockup, with a fixed stretch.

Parameters:
SYNC_STAGES, 2, depth of the reset-release synchroniser; legal range >= 2
PO_HOLD, 16, CLK cycles PORESETN stays low after synchronised release; legal range >= 1
SYS_HOLD, 8, CLK cycles between PORESETN and HRESETN release, and HRESETN low time on a system reset; legal range >= 1

Ports:
CLK  input  1  single system clock
RST  input  1  raw reset, asynchronous, active-high
SYSRESETREQ  input  1  core system reset request, CLK-synchronous
LOCKUP  input  1  core lockup indication, CLK-synchronous
LOCKUPRESET  input  1  quasi-static enable; 1 = lockup triggers a system reset
PORESETN  output  1  power-on reset to debug/core, active-low
HRESETN  output  1  AHB/system reset, active-low
RSTBUSY  output  1  high while the sequencer is in any state other than RUN

Behaviour:
- Interface: one clock CLK; reset RST is asynchronous and active-high.
- RST high, asynchronous: PORESETN=0, HRESETN=0, RSTBUSY=1, synchroniser flops=0, counter=0, state=PO_WAIT.
- Synchroniser: SYNC_STAGES-flop chain that shifts in 1. It is cleared asynchronously by RST. Its output is rel_s.
- All outputs are registered. They are decoded from registered state; there are no combinational paths from inputs to outputs.
- Counter width is $clog2(max(PO_HOLD,SYS_HOLD)+1). The counter clears on every state change.
- PO_WAIT: leave for PO_HOLD when rel_s=1. This takes SYNC_STAGES edges after RST falls, with RST falling between edges.
- PO_HOLD: count PO_HOLD edges, then go to SYS_HOLD and set PORESETN=1. PORESETN rises on edge SYNC_STAGES+PO_HOLD after RST falls (edge 18 with defaults).
- SYS_HOLD: count SYS_HOLD edges, then go to RUN and set HRESETN=1 and RSTBUSY=0. With defaults this is edge 26.
- RUN: trigger = SYSRESETREQ | (LOCKUP & LOCKUPRESET).
  - On trigger, the next edge enters SYS_RST with HRESETN=0 and RSTBUSY=1. PORESETN stays 1.
- SYS_RST: HRESETN is held low for exactly SYS_HOLD cycles, whatever the trigger does during that time.
  - At the end of the count, if trigger=0: go to RUN with HRESETN=1.
  - At the end of the count, if trigger=1: restart the count and stay in SYS_RST.
- Triggers are ignored in PO_WAIT, PO_HOLD and SYS_HOLD.
- Precedence:
  - RST overrides everything at any time, including mid-SYS_RST and mid-count. It always returns the block to PO_WAIT with both resets low.
  - A glitch on RST shorter than a cycle still fully restarts the sequence.
- LOCKUP with LOCKUPRESET=0 has no effect.

Optional Feature:
Macro RSTSEQ_CAUSE_EN.
- Defined: adds input RSTCAUSECLR (1 bit, CLK-synchronous) and output RSTCAUSE (3 bits, sticky).
  - bit0 = power-on. RST forces RSTCAUSE to 3'b001 asynchronously.
  - bit1 = set on entry to SYS_RST when SYSRESETREQ=1.
  - bit2 = set on entry to SYS_RST when LOCKUP&LOCKUPRESET=1.
  - Both bit1 and bit2 may set together.
  - RSTCAUSECLR=1 for one cycle clears all bits on the next edge. If a set and a clear occur on the same edge, the set wins for that bit and the other bits clear.
  - RSTCAUSE is unaffected by HRESETN.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Power-on, defaults: RST=1 for 5 cycles, then low between edges -> PORESETN rises on edge 18, HRESETN on edge 26, RSTBUSY falls on edge 26. Both resets are low before those edges.
- SYSRESETREQ pulsed 1 cycle in RUN -> HRESETN low on next edge for exactly 8 cycles, PORESETN stays 1, RSTBUSY high for the same 8 cycles. With RSTSEQ_CAUSE_EN, RSTCAUSE=3'b011.
- LOCKUP=1 held with LOCKUPRESET=0 -> no change. Set LOCKUPRESET=1 -> SYS_RST. Keep LOCKUP=1 for 20 cycles -> HRESETN low 24 cycles (3 hold periods), then releases one edge after the hold period in which LOCKUP drops.
- RST asserted 3 cycles into SYS_RST -> PORESETN and HRESETN go low immediately without a clock edge. The full 18/26 edge sequence repeats after release.
- SYSRESETREQ held high during PO_HOLD and SYS_HOLD, dropped before edge 26 -> HRESETN still releases on edge 26 and no SYS_RST occurs.
- RSTSEQ_CAUSE_EN: RSTCAUSECLR and SYSRESETREQ on the same edge in RUN with RSTCAUSE=3'b001 -> RSTCAUSE=3'b010.

Source files
------------

// File: rtl/cmsdk_reset_sequencer.sv
// Staged PORESETN/HRESETN generator with system-reset and lockup re-assertion of HRESETN.
// Optional reset-cause register is built when RSTSEQ_CAUSE_EN is defined.
module cmsdk_reset_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int PO_HOLD     = 16,
   parameter int SYS_HOLD    = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       SYSRESETREQ,
   input  logic       LOCKUP,
   input  logic       LOCKUPRESET,
`ifdef RSTSEQ_CAUSE_EN
   input  logic       RSTCAUSECLR,
   output logic [2:0] RSTCAUSE,
`endif
   output logic       PORESETN,
   output logic       HRESETN,
   output logic       RSTBUSY
);

   localparam int MAX_HOLD = (PO_HOLD > SYS_HOLD) ? PO_HOLD : SYS_HOLD;
   localparam int CW       = $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] PO_LAST  = CW'(PO_HOLD - 1);
   localparam logic [CW-1:0] SYS_LAST = CW'(SYS_HOLD - 1);

   typedef enum logic [2:0] {
      ST_PO_WAIT,
      ST_PO_HOLD,
      ST_SYS_HOLD,
      ST_RUN,
      ST_SYS_RST
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   poresetn_q, poresetn_d;
   logic                   hresetn_q, hresetn_d;
   logic                   rstbusy_q, rstbusy_d;
   logic                   rel_s, rel_nxt, trigger;

   // PO_WAIT exits on the edge that loads 1 into the last stage, so the
   // hold count begins together with the rise of rel_s.
   assign sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
   assign rel_s   = sync_q[SYNC_STAGES-1];
   assign rel_nxt = sync_q[SYNC_STAGES-2];
   assign trigger = SYSRESETREQ | (LOCKUP & LOCKUPRESET);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_PO_WAIT: begin
            if (rel_nxt) state_d = ST_PO_HOLD;
         end
         ST_PO_HOLD: begin
            if (rel_s) begin
               if (cnt_q == PO_LAST) state_d = ST_SYS_HOLD;
               else                  cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_SYS_HOLD: begin
            if (cnt_q == SYS_LAST) state_d = ST_RUN;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         ST_RUN: begin
            if (trigger) state_d = ST_SYS_RST;
         end
         ST_SYS_RST: begin
            if (cnt_q == SYS_LAST) begin
               if (trigger) cnt_d   = '0;
               else         state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_PO_WAIT;
      endcase
      if (state_d != state_q) cnt_d = '0;
      poresetn_d = (state_d == ST_SYS_HOLD) || (state_d == ST_RUN) || (state_d == ST_SYS_RST);
      hresetn_d  = (state_d == ST_RUN);
      rstbusy_d  = (state_d != ST_RUN);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= ST_PO_WAIT;
         cnt_q      <= '0;
         sync_q     <= '0;
         poresetn_q <= 1'b0;
         hresetn_q  <= 1'b0;
         rstbusy_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sync_q     <= sync_d;
         poresetn_q <= poresetn_d;
         hresetn_q  <= hresetn_d;
         rstbusy_q  <= rstbusy_d;
      end
   end

   assign PORESETN = poresetn_q;
   assign HRESETN  = hresetn_q;
   assign RSTBUSY  = rstbusy_q;

`ifdef RSTSEQ_CAUSE_EN
   logic [2:0] rstcause_q, rstcause_d;
   logic       sys_entry;

   assign sys_entry = (state_q == ST_RUN) && (state_d == ST_SYS_RST);

   // A clear drops every bit, but a cause recorded on the same edge survives.
   always_comb begin
      rstcause_d = RSTCAUSECLR ? 3'b000 : rstcause_q;
      if (sys_entry) rstcause_d = rstcause_d | {LOCKUP & LOCKUPRESET, SYSRESETREQ, 1'b0};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) rstcause_q <= 3'b001;
      else     rstcause_q <= rstcause_d;
   end

   assign RSTCAUSE = rstcause_q;
`endif

endmodule
